// File: rtl/mem_req_axi_bridge_if.sv
// ----------------------------------------------------------------------------
// mem_req_axi_bridge_if
// Bundles the cache request/return interface and the AXI4 master channels
// seen by mem_req_axi_bridge.
//   master : bridge side. It answers cache requests and drives the AXI master
//            signals.
//   slave  : environment side. It holds the cache requester plus the AXI
//            interconnect.
// Cache side : rd_req/rd_type/rd_addr/rd_rdy, ret_valid/ret_last/ret_data,
//              wr_req/wr_type/wr_addr/wr_wstrb/wr_data/wr_rdy
// AXI side   : AR, R, AW, W and B channels (id/lock/cache/prot not included)
// ----------------------------------------------------------------------------
interface mem_req_axi_bridge_if #(
  parameter int LINE_WORDS = 4
);
  logic                      rd_req;
  logic [2:0]                rd_type;
  logic [31:0]               rd_addr;
  logic                      rd_rdy;
  logic                      ret_valid;
  logic                      ret_last;
  logic [31:0]               ret_data;
  logic                      wr_req;
  logic [2:0]                wr_type;
  logic [31:0]               wr_addr;
  logic [3:0]                wr_wstrb;
  logic [32*LINE_WORDS-1:0]  wr_data;
  logic                      wr_rdy;
  logic [31:0]               araddr;
  logic [7:0]                arlen;
  logic [2:0]                arsize;
  logic [1:0]                arburst;
  logic                      arvalid;
  logic                      arready;
  logic [31:0]               rdata;
  logic [1:0]                rresp;
  logic                      rlast;
  logic                      rvalid;
  logic                      rready;
  logic [31:0]               awaddr;
  logic [7:0]                awlen;
  logic [2:0]                awsize;
  logic [1:0]                awburst;
  logic                      awvalid;
  logic                      awready;
  logic [31:0]               wdata;
  logic [3:0]                wstrb;
  logic                      wlast;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;

  modport master (
    input  rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    input  arready, rdata, rresp, rlast, rvalid, awready, wready, bresp, bvalid,
    output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
    output araddr, arlen, arsize, arburst, arvalid, rready,
    output awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready
  );

  modport slave (
    output rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    output arready, rdata, rresp, rlast, rvalid, awready, wready, bresp, bvalid,
    input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    input  awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready
  );
endinterface

// File: rtl/mem_req_axi_bridge.sv
// ----------------------------------------------------------------------------
// mem_req_axi_bridge
// Turns cache read/write requests into AXI4 transactions. At most one read
// and one write are in flight at a time. Read beats are passed straight back
// as ret_valid/ret_data/ret_last. A read to a line that has a write in flight
// (or being accepted this cycle) is held off. This keeps read-after-write
// ordering intact.
// Ports:
//   clk  : core clock (rising edge)
//   rst  : synchronous active-high reset
//   bus  : mem_req_axi_bridge_if.master (cache request side + AXI master)
// ----------------------------------------------------------------------------
module mem_req_axi_bridge #(
  parameter int LINE_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_req_axi_bridge_if.master bus
);
  localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_REQ = 2'd1, W_RESP = 2'd2} wr_state_t;

  function automatic logic is_line(input logic [2:0] t);
    return (t == 3'b100);
  endfunction

  function automatic logic [31:0] ax_addr(input logic [31:0] a, input logic [2:0] t);
    return is_line(t) ? {a[31:4], 4'b0000} : a;
  endfunction

  function automatic logic [7:0] ax_len(input logic [2:0] t);
    return is_line(t) ? LINE_LEN : 8'd0;
  endfunction

  function automatic logic [2:0] ax_size(input logic [2:0] t);
    return is_line(t) ? 3'b010 : {1'b0, t[1:0]};
  endfunction

  rd_state_t          rd_state_r, rd_next_s;
  logic [31:0]        rd_addr_r;
  logic [2:0]         rd_type_r;
  wr_state_t          wr_state_r, wr_next_s;
  logic [31:0]        wr_addr_r;
  logic [2:0]         wr_type_r;
  logic [3:0]         wr_wstrb_r;
  logic [31:0]        wr_buf_r [LINE_WORDS];
  logic [CNT_W-1:0]   wr_cnt_r;
  logic               aw_done_r;
  logic               w_done_r;

  logic rd_rdy_s, rd_accept_s, wr_idle_s, wr_accept_s, hazard_s;
  logic aw_fire_s, w_fire_s, cnt_at_last_s, w_last_fire_s;
  logic resp_unused_s;

  assign resp_unused_s = ^{bus.rresp, bus.bresp};

  // Read ordering: hold off a read that targets a line with a write pending or starting now.
  assign wr_idle_s   = (wr_state_r == W_IDLE);
  assign wr_accept_s = bus.wr_req && wr_idle_s;
  assign hazard_s    = (!wr_idle_s && (bus.rd_addr[31:4] == wr_addr_r[31:4])) ||
                       (wr_accept_s && (bus.rd_addr[31:4] == bus.wr_addr[31:4]));
  assign rd_rdy_s    = (rd_state_r == R_IDLE) && !hazard_s;
  assign rd_accept_s = bus.rd_req && rd_rdy_s;
  assign bus.rd_rdy  = rd_rdy_s;
  assign bus.wr_rdy  = wr_idle_s;

  assign bus.araddr   = ax_addr(rd_addr_r, rd_type_r);
  assign bus.arlen    = ax_len(rd_type_r);
  assign bus.arsize   = ax_size(rd_type_r);
  assign bus.arburst  = 2'b01;
  assign bus.ret_data = bus.rdata;

  assign bus.awaddr  = ax_addr(wr_addr_r, wr_type_r);
  assign bus.awlen   = ax_len(wr_type_r);
  assign bus.awsize  = ax_size(wr_type_r);
  assign bus.awburst = 2'b01;
  assign bus.wdata   = wr_buf_r[wr_cnt_r];
  assign bus.wstrb   = is_line(wr_type_r) ? 4'hf : wr_wstrb_r;

  assign cnt_at_last_s = ({{(8-CNT_W){1'b0}}, wr_cnt_r} == ax_len(wr_type_r));
  assign aw_fire_s     = (wr_state_r == W_REQ) && !aw_done_r && bus.awready;
  assign w_fire_s      = (wr_state_r == W_REQ) && !w_done_r && bus.wready;
  assign w_last_fire_s = w_fire_s && cnt_at_last_s;

  // Read FSM state and request capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_r <= R_IDLE;
      rd_addr_r  <= 32'h0000_0000;
      rd_type_r  <= 3'b000;
    end else begin
      rd_state_r <= rd_next_s;
      if (rd_accept_s) begin
        rd_addr_r <= bus.rd_addr;
        rd_type_r <= bus.rd_type;
      end
    end
  end

  // Read FSM next state and AR/R channel controls.
  always_comb begin
    rd_next_s     = rd_state_r;
    bus.arvalid   = 1'b0;
    bus.rready    = 1'b0;
    bus.ret_valid = 1'b0;
    bus.ret_last  = 1'b0;
    case (rd_state_r)
      R_IDLE: begin
        if (rd_accept_s) rd_next_s = R_AR;
        else             rd_next_s = R_IDLE;
      end
      R_AR: begin
        bus.arvalid = 1'b1;
        if (bus.arready) rd_next_s = R_DATA;
        else             rd_next_s = R_AR;
      end
      R_DATA: begin
        bus.rready    = 1'b1;
        bus.ret_valid = bus.rvalid;
        bus.ret_last  = bus.rlast;
        if (bus.rvalid && bus.rlast) rd_next_s = R_IDLE;
        else                         rd_next_s = R_DATA;
      end
      default: rd_next_s = R_IDLE;
    endcase
  end

  // Write FSM state, request capture, beat counter and handshake-done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_r <= W_IDLE;
      wr_addr_r  <= 32'h0000_0000;
      wr_type_r  <= 3'b000;
      wr_wstrb_r <= 4'h0;
      wr_cnt_r   <= '0;
      aw_done_r  <= 1'b0;
      w_done_r   <= 1'b0;
      for (int i = 0; i < LINE_WORDS; i++) wr_buf_r[i] <= 32'h0000_0000;
    end else begin
      wr_state_r <= wr_next_s;
      if (wr_accept_s) begin
        wr_addr_r  <= bus.wr_addr;
        wr_type_r  <= bus.wr_type;
        wr_wstrb_r <= bus.wr_wstrb;
        wr_cnt_r   <= '0;
        aw_done_r  <= 1'b0;
        w_done_r   <= 1'b0;
        for (int i = 0; i < LINE_WORDS; i++) wr_buf_r[i] <= bus.wr_data[32*i +: 32];
      end else begin
        if (aw_fire_s) aw_done_r <= 1'b1;
        // Counter parks on the last beat so wdata never indexes past the buffer.
        if (w_fire_s) begin
          if (cnt_at_last_s) w_done_r <= 1'b1;
          else               wr_cnt_r <= wr_cnt_r + CNT_W'(1);
        end
      end
    end
  end

  // Write FSM next state and AW/W/B channel controls; AW and last W may finish in any order.
  always_comb begin
    wr_next_s   = wr_state_r;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.wlast   = 1'b0;
    bus.bready  = 1'b0;
    case (wr_state_r)
      W_IDLE: begin
        if (wr_accept_s) wr_next_s = W_REQ;
        else             wr_next_s = W_IDLE;
      end
      W_REQ: begin
        bus.awvalid = !aw_done_r;
        bus.wvalid  = !w_done_r;
        bus.wlast   = !w_done_r && cnt_at_last_s;
        if ((aw_done_r || aw_fire_s) && (w_done_r || w_last_fire_s)) wr_next_s = W_RESP;
        else                                                         wr_next_s = W_REQ;
      end
      W_RESP: begin
        bus.bready = 1'b1;
        if (bus.bvalid) wr_next_s = W_IDLE;
        else            wr_next_s = W_RESP;
      end
      default: wr_next_s = W_IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_req_axi_bridge.sv
// ----------------------------------------------------------------------------
// tb_mem_req_axi_bridge
// Directed bench for mem_req_axi_bridge. Expected read-return beats and W
// beats are queued when stimulus is driven. A negedge monitor pops and
// compares them when the bridge produces them.
// ----------------------------------------------------------------------------
module tb_mem_req_axi_bridge;
  bit   clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  logic [32:0] exp_ret [$];   // {last, data}
  logic [36:0] exp_w   [$];   // {last, strb, data}
  logic [31:0] rbeats  [$];

  mem_req_axi_bridge_if #(.LINE_WORDS(4)) bus ();

  mem_req_axi_bridge #(.LINE_WORDS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor for the read-return and W channels.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.ret_valid === 1'b1) begin
        if (exp_ret.size() == 0) chk("ret_unexpected", 32'd1, 32'd0);
        else begin
          logic [32:0] e;
          e = exp_ret.pop_front();
          chk("ret_data", bus.ret_data, e[31:0]);
          chk("ret_last", 32'(bus.ret_last), 32'(e[32]));
        end
      end
      if (bus.wvalid === 1'b1 && bus.wready === 1'b1) begin
        if (exp_w.size() == 0) chk("w_unexpected", 32'd1, 32'd0);
        else begin
          logic [36:0] e;
          e = exp_w.pop_front();
          chk("wdata", bus.wdata, e[31:0]);
          chk("wstrb", 32'(bus.wstrb), 32'(e[35:32]));
          chk("wlast", 32'(bus.wlast), 32'(e[36]));
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Full read: accept, AR with arready at once, beats from rbeats (optional gap before beat 2).
  task automatic run_read(input logic [31:0] addr, input logic [2:0] typ,
                          input logic [31:0] e_araddr, input logic [7:0] e_len,
                          input logic [2:0] e_size, input bit gap);
    int nb;
    nb = rbeats.size();
    bus.rd_req = 1'b1; bus.rd_addr = addr; bus.rd_type = typ;
    @(negedge clk);
    chk("rd_rdy_accept", 32'(bus.rd_rdy), 32'd1);
    nxt();
    bus.rd_req = 1'b0; bus.rd_addr = 32'hFFFF_FFF0; bus.rd_type = 3'b000; bus.arready = 1'b1;
    @(negedge clk);
    chk("arvalid", 32'(bus.arvalid), 32'd1);
    chk("araddr", bus.araddr, e_araddr);
    chk("arlen", 32'(bus.arlen), 32'(e_len));
    chk("arsize", 32'(bus.arsize), 32'(e_size));
    chk("arburst", 32'(bus.arburst), 32'd1);
    nxt();
    bus.arready = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (gap && i == 2) begin
        bus.rvalid = 1'b0; bus.rdata = 32'h0000_0099; bus.rlast = 1'b0;
        @(negedge clk);
        chk("gap_no_ret_valid", 32'(bus.ret_valid), 32'd0);
        nxt();
      end
      bus.rvalid = 1'b1; bus.rdata = rbeats.pop_front(); bus.rlast = (i == nb - 1);
      exp_ret.push_back({bus.rlast, bus.rdata});
      @(negedge clk);
      chk("rready", 32'(bus.rready), 32'd1);
      nxt();
    end
    bus.rvalid = 1'b0; bus.rlast = 1'b0;
    @(negedge clk);
    chk("rd_rdy_after_last", 32'(bus.rd_rdy), 32'd1);
    chk("ret_queue_empty", 32'(exp_ret.size()), 32'd0);
  endtask

  // Full write: W beats back to back, awready immediate or held until aw_delay cycles after last beat.
  task automatic run_write(input logic [31:0] addr, input logic [2:0] typ, input logic [3:0] strb,
                           input logic [127:0] data, input logic [31:0] e_awaddr,
                           input logic [7:0] e_len, input logic [2:0] e_size,
                           input logic [3:0] e_strb, input int aw_delay);
    int nb;
    int n;
    bit seen;
    nb = int'(e_len) + 1;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < nb; i++) exp_w.push_back({(i == nb - 1), e_strb, data[32*i +: 32]});
    bus.wr_req = 1'b1; bus.wr_addr = addr; bus.wr_type = typ; bus.wr_wstrb = strb; bus.wr_data = data;
    @(negedge clk);
    chk("wr_rdy_accept", 32'(bus.wr_rdy), 32'd1);
    nxt();
    bus.wr_req = 1'b0; bus.wr_data = '1; bus.wr_wstrb = 4'h0; bus.wready = 1'b1;
    bus.awready = (aw_delay == 0);
    while (n < 40) begin
      @(negedge clk);
      if (bus.awvalid === 1'b1 && !seen) begin
        seen = 1'b1;
        chk("awaddr", bus.awaddr, e_awaddr);
        chk("awlen", 32'(bus.awlen), 32'(e_len));
        chk("awsize", 32'(bus.awsize), 32'(e_size));
        chk("awburst", 32'(bus.awburst), 32'd1);
      end
      if (bus.bready === 1'b1) break;
      nxt();
      n++;
      bus.awready = (aw_delay == 0) || (n >= nb - 1 + aw_delay);
    end
    chk("aw_seen", 32'(seen), 32'd1);
    chk("bready_reached", 32'(bus.bready), 32'd1);
    if (aw_delay == 0) chk("bready_cycle", 32'(n), 32'(nb));
    chk("wr_rdy_busy", 32'(bus.wr_rdy), 32'd0);
    nxt();
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b1;
    nxt();
    bus.bvalid = 1'b0;
    @(negedge clk);
    chk("wr_rdy_after_b", 32'(bus.wr_rdy), 32'd1);
    chk("bready_low", 32'(bus.bready), 32'd0);
    chk("w_queue_empty", 32'(exp_w.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.rd_req = 1'b0; bus.rd_type = 3'b000; bus.rd_addr = 32'h0;
    bus.wr_req = 1'b0; bus.wr_type = 3'b000; bus.wr_addr = 32'h0; bus.wr_wstrb = 4'h0; bus.wr_data = '0;
    bus.arready = 1'b0; bus.rdata = 32'h5A5A_5A5A; bus.rresp = 2'b00; bus.rlast = 1'b0; bus.rvalid = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bresp = 2'b00; bus.bvalid = 1'b0;
    nxt(); nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rd_rdy", 32'(bus.rd_rdy), 32'd1);
    chk("rst_wr_rdy", 32'(bus.wr_rdy), 32'd1);
    chk("rst_valids", 32'({bus.arvalid, bus.awvalid, bus.wvalid, bus.wlast}), 32'd0);
    chk("rst_readies", 32'({bus.rready, bus.bready, bus.ret_valid, bus.ret_last}), 32'd0);
    chk("rst_ret_data", bus.ret_data, 32'h5A5A_5A5A);
    nxt();

    // Word read
    rbeats.push_back(32'hDEAD_BEEF);
    run_read(32'h1FAF_0004, 3'b010, 32'h1FAF_0004, 8'd0, 3'd2, 1'b0);
    nxt();

    // Line read with a gap in rvalid
    rbeats.push_back(32'h11); rbeats.push_back(32'h22); rbeats.push_back(32'h33); rbeats.push_back(32'h44);
    run_read(32'h0000_1238, 3'b100, 32'h0000_1230, 8'd3, 3'd2, 1'b1);
    nxt();

    // Line write, awready late
    run_write(32'h0000_2000, 3'b100, 4'h0, {32'hA3, 32'hA2, 32'hA1, 32'hA0},
              32'h0000_2000, 8'd3, 3'd2, 4'hf, 3);
    nxt();

    // Byte write
    run_write(32'h0000_3003, 3'b000, 4'b1000, {96'h0, 32'hBB00_0000},
              32'h0000_3003, 8'd0, 3'd0, 4'b1000, 0);
    nxt();

    // Same-line read and write in the same cycle: write wins, read waits for B
    exp_w.push_back({1'b1, 4'hf, 32'hCAFE_0001});
    bus.wr_req = 1'b1; bus.wr_addr = 32'h0000_4000; bus.wr_type = 3'b010; bus.wr_wstrb = 4'hf;
    bus.wr_data = {96'h0, 32'hCAFE_0001};
    bus.rd_req = 1'b1; bus.rd_addr = 32'h0000_4008; bus.rd_type = 3'b010;
    @(negedge clk);
    chk("haz_wr_rdy", 32'(bus.wr_rdy), 32'd1);
    chk("haz_same_cycle", 32'(bus.rd_rdy), 32'd0);
    nxt();
    bus.wr_req = 1'b0; bus.wr_addr = 32'h0000_9000; bus.awready = 1'b1; bus.wready = 1'b1;
    @(negedge clk);
    chk("haz_inflight", 32'(bus.rd_rdy), 32'd0);
    chk("haz_awvalid", 32'(bus.awvalid), 32'd1);
    nxt();
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b1;
    @(negedge clk);
    chk("haz_bready", 32'(bus.bready), 32'd1);
    chk("haz_resp", 32'(bus.rd_rdy), 32'd0);
    nxt();
    bus.bvalid = 1'b0;
    rbeats.push_back(32'h4444_0008);
    run_read(32'h0000_4008, 3'b010, 32'h0000_4008, 8'd0, 3'd2, 1'b0);
    nxt();

    // Different lines: both accepted in the same cycle and run concurrently
    exp_w.push_back({1'b1, 4'h3, 32'h1234_5678});
    bus.wr_req = 1'b1; bus.wr_addr = 32'h0000_4000; bus.wr_type = 3'b001; bus.wr_wstrb = 4'h3;
    bus.wr_data = {96'h0, 32'h1234_5678};
    bus.rd_req = 1'b1; bus.rd_addr = 32'h0000_5000; bus.rd_type = 3'b010;
    @(negedge clk);
    chk("conc_wr_rdy", 32'(bus.wr_rdy), 32'd1);
    chk("conc_rd_rdy", 32'(bus.rd_rdy), 32'd1);
    nxt();
    bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.arready = 1'b1; bus.awready = 1'b1; bus.wready = 1'b1;
    @(negedge clk);
    chk("conc_araddr", bus.araddr, 32'h0000_5000);
    chk("conc_awaddr", bus.awaddr, 32'h0000_4000);
    chk("conc_awsize", 32'(bus.awsize), 32'd1);
    chk("conc_both_valid", 32'({bus.arvalid, bus.awvalid, bus.wvalid}), 32'd7);
    nxt();
    bus.arready = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
    bus.rvalid = 1'b1; bus.rdata = 32'h0000_0055; bus.rlast = 1'b1; bus.bvalid = 1'b1;
    exp_ret.push_back({1'b1, 32'h0000_0055});
    @(negedge clk);
    chk("conc_rready", 32'(bus.rready), 32'd1);
    chk("conc_bready", 32'(bus.bready), 32'd1);
    nxt();
    bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.bvalid = 1'b0;
    @(negedge clk);
    chk("conc_idle_rdy", 32'({bus.rd_rdy, bus.wr_rdy}), 32'd3);
    chk("conc_queues", 32'(exp_ret.size() + exp_w.size()), 32'd0);
    nxt();

    // Reset while in R_DATA and W_REQ
    bus.rd_req = 1'b1; bus.rd_addr = 32'h0000_6000; bus.rd_type = 3'b100;
    bus.wr_req = 1'b1; bus.wr_addr = 32'h0000_7000; bus.wr_type = 3'b100; bus.wr_data = '0;
    nxt();
    bus.rd_req = 1'b0; bus.wr_req = 1'b0; bus.arready = 1'b1;
    nxt();
    bus.arready = 1'b0;
    @(negedge clk);
    chk("pre_rst_rready", 32'(bus.rready), 32'd1);
    chk("pre_rst_wvalid", 32'(bus.wvalid), 32'd1);
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valids", 32'({bus.arvalid, bus.awvalid, bus.wvalid}), 32'd0);
    chk("mid_rst_readies", 32'({bus.rready, bus.bready}), 32'd0);
    chk("mid_rst_rdy", 32'({bus.rd_rdy, bus.wr_rdy}), 32'd3);
    nxt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
